// File: rtl/io_countdown_timer_if.sv
// io_bus_interface
//
// Purpose: memory-mapped peripheral bus between the processor's io_bus
// master port and its targets. Strobes are single-cycle; read data is
// returned by the target one cycle after read_en.
//
// Signals:
//   write_en    initiator -> target  1   write strobe
//   read_en     initiator -> target  1   read strobe
//   address     initiator -> target  32  byte address
//   write_data  initiator -> target  32  write data
//   read_data   target -> initiator  32  read data, valid the cycle after read_en
interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport initiator (
        output write_en,
        output read_en,
        output address,
        output write_data,
        input  read_data
    );

    modport target (
        input  write_en,
        input  read_en,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/io_countdown_timer.sv
// io_countdown_timer
//
// Purpose: programmable countdown timer peripheral on the io_bus. A 32-bit
// prescaler divides the clock into ticks; each tick decrements COUNT. When a
// tick lands on COUNT==1 the timer expires: STATUS.expired is set and COUNT
// either reloads from RELOAD (auto_reload) or goes idle at 0. The level
// interrupt is expired & irq_en.
//
// Register map (byte offsets from BASE_ADDRESS, full-address match):
//   +0x00 COUNT     R/W
//   +0x04 RELOAD    R/W
//   +0x08 CONTROL   R/W  [0]=enable [1]=auto_reload [2]=irq_en, others read 0
//   +0x0C STATUS    [0]=expired, read returns it, write 1 clears it
//   +0x10 PRESCALE  R/W
// Any other address reads 0 and ignores writes.
//
// Ports:
//   clk              in   clock
//   reset            in   asynchronous, active-high reset
//   io_bus           io_bus_interface.target (write_en, read_en, address,
//                    write_data in; read_data out, registered, 1-cycle latency)
//   timer_interrupt  out  level interrupt, expired & irq_en
module io_countdown_timer #(
    parameter logic [31:0] BASE_ADDRESS = 32'hffff_0100
) (
    input  logic            clk,
    input  logic            reset,
    io_bus_interface.target io_bus,
    output logic            timer_interrupt
);

    localparam logic [31:0] ADDR_COUNT    = BASE_ADDRESS + 32'h0000_0000;
    localparam logic [31:0] ADDR_RELOAD   = BASE_ADDRESS + 32'h0000_0004;
    localparam logic [31:0] ADDR_CONTROL  = BASE_ADDRESS + 32'h0000_0008;
    localparam logic [31:0] ADDR_STATUS   = BASE_ADDRESS + 32'h0000_000C;
    localparam logic [31:0] ADDR_PRESCALE = BASE_ADDRESS + 32'h0000_0010;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] count_q,     count_d;
    logic [31:0] reload_q,    reload_d;
    logic [31:0] prescale_q,  prescale_d;
    logic [31:0] psc_cnt_q,   psc_cnt_d;
    logic        enable_q,    enable_d;
    logic        auto_rld_q,  auto_rld_d;
    logic        irq_en_q,    irq_en_d;
    logic        expired_q,   expired_d;
    logic [31:0] read_data_q, read_data_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_count;
    logic sel_reload;
    logic sel_control;
    logic sel_status;
    logic sel_prescale;

    always_comb begin
        sel_count    = (io_bus.address == ADDR_COUNT);
        sel_reload   = (io_bus.address == ADDR_RELOAD);
        sel_control  = (io_bus.address == ADDR_CONTROL);
        sel_status   = (io_bus.address == ADDR_STATUS);
        sel_prescale = (io_bus.address == ADDR_PRESCALE);
    end

    logic wr_count;
    logic wr_reload;
    logic wr_control;
    logic wr_status;
    logic wr_prescale;

    always_comb begin
        wr_count    = io_bus.write_en && sel_count;
        wr_reload   = io_bus.write_en && sel_reload;
        wr_control  = io_bus.write_en && sel_control;
        wr_status   = io_bus.write_en && sel_status;
        wr_prescale = io_bus.write_en && sel_prescale;
    end

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    // A tick is produced on the cycle the prescale counter reaches PRESCALE,
    // so PRESCALE=N yields one tick every N+1 enabled cycles.
    logic tick;

    always_comb begin
        tick = enable_q && (psc_cnt_q == prescale_q);
    end

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (wr_control || wr_prescale) begin
            // Reconfiguring restarts the prescale period from a clean phase.
            psc_cnt_d = 32'd0;
        end else if (enable_q) begin
            psc_cnt_d = tick ? 32'd0 : psc_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Counter and expiry
    // ------------------------------------------------------------------
    // A software COUNT write overrides whatever the tick would have done,
    // including suppressing an expiry that would otherwise fire this cycle.
    logic expire_evt;

    always_comb begin
        expire_evt = tick && (count_q == 32'd1) && !wr_count;
    end

    always_comb begin
        count_d = count_q;
        if (wr_count) begin
            count_d = io_bus.write_data;
        end else if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                count_d = auto_rld_q ? reload_q : 32'd0;
            end
        end
    end

    // Expiry has priority over the write-1-to-clear so an event is never lost.
    always_comb begin
        expired_d = expired_q;
        if (expire_evt) begin
            expired_d = 1'b1;
        end else if (wr_status && io_bus.write_data[0]) begin
            expired_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_comb begin
        reload_d   = wr_reload   ? io_bus.write_data : reload_q;
        prescale_d = wr_prescale ? io_bus.write_data : prescale_q;
        enable_d   = enable_q;
        auto_rld_d = auto_rld_q;
        irq_en_d   = irq_en_q;
        if (wr_control) begin
            enable_d   = io_bus.write_data[0];
            auto_rld_d = io_bus.write_data[1];
            irq_en_d   = io_bus.write_data[2];
        end
    end

    // ------------------------------------------------------------------
    // Read-back
    // ------------------------------------------------------------------
    // The mux sees the current (pre-write) register values, so a read issued
    // together with a write to the same register returns the old contents.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'd0;
        if (sel_count) begin
            rd_mux = count_q;
        end else if (sel_reload) begin
            rd_mux = reload_q;
        end else if (sel_control) begin
            rd_mux = {29'd0, irq_en_q, auto_rld_q, enable_q};
        end else if (sel_status) begin
            rd_mux = {31'd0, expired_q};
        end else if (sel_prescale) begin
            rd_mux = prescale_q;
        end
    end

    // read_data only updates on a read strobe and otherwise holds.
    always_comb begin
        read_data_d = io_bus.read_en ? rd_mux : read_data_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= 32'd0;
            reload_q    <= 32'd0;
            prescale_q  <= 32'd0;
            psc_cnt_q   <= 32'd0;
            enable_q    <= 1'b0;
            auto_rld_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            expired_q   <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            count_q     <= count_d;
            reload_q    <= reload_d;
            prescale_q  <= prescale_d;
            psc_cnt_q   <= psc_cnt_d;
            enable_q    <= enable_d;
            auto_rld_q  <= auto_rld_d;
            irq_en_q    <= irq_en_d;
            expired_q   <= expired_d;
            read_data_q <= read_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Built only from flops, so the interrupt is glitch-free and has no
    // added latency beyond the expiry register itself.
    assign timer_interrupt  = expired_q & irq_en_q;
    assign io_bus.read_data = read_data_q;

endmodule

// File: tb/tb_io_countdown_timer.sv
// tb_io_countdown_timer
//
// Purpose: directed test of io_countdown_timer. Bus accesses are launched on
// the falling edge, take effect on the following rising edge, and results are
// sampled on the next falling edge.
module tb_io_countdown_timer;

    localparam logic [31:0] BASE       = 32'hffff_0100;
    localparam logic [31:0] A_COUNT    = BASE + 32'h00;
    localparam logic [31:0] A_RELOAD   = BASE + 32'h04;
    localparam logic [31:0] A_CONTROL  = BASE + 32'h08;
    localparam logic [31:0] A_STATUS   = BASE + 32'h0C;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h10;

    logic clk;
    logic reset;
    logic timer_interrupt;

    io_bus_interface bus ();

    io_countdown_timer #(
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_bus          (bus),
        .timer_interrupt (timer_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks are entered on a falling edge and return on the next one.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.write_data = data;
        bus.write_en   = 1'b1;
        @(negedge clk);
        bus.write_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.address = addr;
        bus.read_en = 1'b1;
        @(negedge clk);
        bus.read_en = 1'b0;
        data        = bus.read_data;
    endtask

    task automatic bus_rw(input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        bus.address    = addr;
        bus.write_data = wdata;
        bus.write_en   = 1'b1;
        bus.read_en    = 1'b1;
        @(negedge clk);
        bus.write_en   = 1'b0;
        bus.read_en    = 1'b0;
        rdata          = bus.read_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] rd;

    initial begin
        reset          = 1'b1;
        bus.write_en   = 1'b0;
        bus.read_en    = 1'b0;
        bus.address    = 32'd0;
        bus.write_data = 32'd0;
        idle(3);
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_irq", {31'd0, timer_interrupt}, 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);
        bus_read(A_COUNT, rd);    check("rst_count", rd, 32'd0);
        bus_read(A_RELOAD, rd);   check("rst_reload", rd, 32'd0);
        bus_read(A_CONTROL, rd);  check("rst_control", rd, 32'd0);
        bus_read(A_STATUS, rd);   check("rst_status", rd, 32'd0);
        bus_read(A_PRESCALE, rd); check("rst_prescale", rd, 32'd0);

        // ---------------- one-shot ----------------
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd5);
        bus_write(A_CONTROL, 32'd5);
        idle(4);
        check("oneshot_irq_c4", {31'd0, timer_interrupt}, 32'd0);
        idle(1);
        check("oneshot_irq_c5", {31'd0, timer_interrupt}, 32'd1);
        bus_read(A_COUNT, rd);  check("oneshot_count", rd, 32'd0);
        bus_read(A_STATUS, rd); check("oneshot_status", rd, 32'd1);
        bus_read(A_STATUS, rd); check("oneshot_status_noclr", rd, 32'd1);
        idle(3);
        check("rdata_hold", bus.read_data, 32'd1);
        bus_write(A_STATUS, 32'd1);
        check("oneshot_irq_clr", {31'd0, timer_interrupt}, 32'd0);
        bus_write(A_CONTROL, 32'd0);

        // ---------------- auto-reload with prescale ----------------
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_RELOAD, 32'd2);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CONTROL, 32'd7);
        idle(7);
        check("auto_irq_c7", {31'd0, timer_interrupt}, 32'd0);
        idle(1);
        check("auto_irq_c8", {31'd0, timer_interrupt}, 32'd1);
        bus_write(A_STATUS, 32'd1);
        check("auto_irq_clr", {31'd0, timer_interrupt}, 32'd0);
        idle(6);
        check("auto_irq_c15", {31'd0, timer_interrupt}, 32'd0);
        idle(1);
        check("auto_irq_c16", {31'd0, timer_interrupt}, 32'd1);
        bus_write(A_CONTROL, 32'd0);
        bus_write(A_STATUS, 32'd1);

        // ---------------- COUNT write vs expiry ----------------
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd3);
        bus_write(A_CONTROL, 32'd1);
        idle(2);
        bus_write(A_COUNT, 32'd9);
        bus_read(A_STATUS, rd); check("coll_cnt_noexp", rd, 32'd0);
        bus_read(A_COUNT, rd);  check("coll_cnt_value", rd, 32'd8);
        bus_write(A_CONTROL, 32'd0);

        // ---------------- STATUS clear vs expiry ----------------
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CONTROL, 32'd1);
        bus_write(A_COUNT, 32'd1);
        idle(1);
        bus_write(A_COUNT, 32'd2);
        idle(1);
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, rd); check("coll_stat_keep", rd, 32'd1);
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, rd); check("stat_clear", rd, 32'd0);
        bus_write(A_CONTROL, 32'd0);

        // ---------------- disable / resume ----------------
        bus_write(A_COUNT, 32'd10);
        bus_write(A_CONTROL, 32'd1);
        idle(2);
        bus_write(A_CONTROL, 32'd0);
        idle(20);
        bus_read(A_COUNT, rd);  check("dis_count_frozen", rd, 32'd7);
        bus_read(A_STATUS, rd); check("dis_status", rd, 32'd0);
        bus_write(A_CONTROL, 32'd5);
        idle(6);
        check("resume_irq_t6", {31'd0, timer_interrupt}, 32'd0);
        idle(1);
        check("resume_irq_t7", {31'd0, timer_interrupt}, 32'd1);
        bus_write(A_CONTROL, 32'd0);
        bus_write(A_STATUS, 32'd1);

        // ---------------- decode ----------------
        bus_write(A_COUNT, 32'h11);
        bus_write(A_RELOAD, 32'h22);
        bus_write(A_PRESCALE, 32'h33);
        bus_write(A_CONTROL, 32'hFF);
        bus_read(A_CONTROL, rd); check("ctrl_mask", rd, 32'd7);
        bus_write(A_CONTROL, 32'd2);
        bus_write(BASE + 32'h14, 32'hDEAD_BEEF);
        bus_write(BASE + 32'h20, 32'hDEAD_BEEF);
        bus_write(32'h0000_0100, 32'hDEAD_BEEF);
        bus_read(BASE + 32'h14, rd);  check("dec_rd_14", rd, 32'd0);
        bus_read(BASE + 32'h20, rd);  check("dec_rd_20", rd, 32'd0);
        bus_read(32'h0000_0100, rd);  check("dec_rd_alias", rd, 32'd0);
        bus_read(A_COUNT, rd);    check("dec_count", rd, 32'h11);
        bus_read(A_RELOAD, rd);   check("dec_reload", rd, 32'h22);
        bus_read(A_CONTROL, rd);  check("dec_control", rd, 32'd2);
        bus_read(A_STATUS, rd);   check("dec_status", rd, 32'd0);
        bus_read(A_PRESCALE, rd); check("dec_prescale", rd, 32'h33);

        // ---------------- simultaneous read/write ----------------
        bus_rw(A_COUNT, 32'h55, rd); check("rw_old", rd, 32'h11);
        bus_read(A_COUNT, rd);       check("rw_new", rd, 32'h55);

        // ---------------- async reset mid-count ----------------
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CONTROL, 32'd5);
        idle(2);
        check("pre_rst_irq", {31'd0, timer_interrupt}, 32'd1);
        bus_write(A_COUNT, 32'd100);
        bus_read(A_RELOAD, rd); check("pre_rst_reload", rd, 32'h22);
        #2 reset = 1'b1;
        #1;
        check("arst_irq", {31'd0, timer_interrupt}, 32'd0);
        check("arst_rdata", bus.read_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_COUNT, rd);    check("arst_count", rd, 32'd0);
        bus_read(A_RELOAD, rd);   check("arst_reload", rd, 32'd0);
        bus_read(A_CONTROL, rd);  check("arst_control", rd, 32'd0);
        bus_read(A_STATUS, rd);   check("arst_status", rd, 32'd0);
        bus_read(A_PRESCALE, rd); check("arst_prescale", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
